mem_wb_skid_reg: RTL and testbench
==================================

// Module: mem_wb_skid_reg
// PURPOSE
//  Parametrised MEM->WB pipeline register with valid/ready handshake, 2-entry skid
//  buffer, synchronous flush and NUM_CH parallel write-back channels. Sits between
//  the MEM stage and the register-file write port(s). Lets WB back-pressure MEM
//  without a combinational ready path and without dropping writes.
// PARAMETERS
//  NUM_CH     1   number of parallel write-back channels
//  ADDR_W     5   register address width per channel
//  DATA_W     32  write data width per channel
//  ZERO_SUPP  1   1: write-enable forced 0 when channel addr == 0 (x0 hardwired)
//  CNT_W      16  retire counter width
// PORTS
//  clk                   in   1               clock, rising edge
//  rst                   in   1               asynchronous, active-low reset
//  flush_i               in   1               sync flush: drop all held entries
//  mem_valid_i           in   1               MEM presents a beat
//  mem_ready_o           out  1               block can accept a beat (registered)
//  mem_write_reg_en_i    in   NUM_CH          per-channel write enable
//  mem_write_reg_addr_i  in   NUM_CH*ADDR_W   per-channel address, ch0 in LSBs
//  mem_write_reg_data_i  in   NUM_CH*DATA_W   per-channel data, ch0 in LSBs
//  wb_valid_o            out  1               WB beat valid
//  wb_ready_i            in   1               WB consumes beat
//  wb_write_reg_en_o     out  NUM_CH          per-channel enable, 0 whenever !wb_valid_o
//  wb_write_reg_addr_o   out  NUM_CH*ADDR_W   per-channel address
//  wb_write_reg_data_o   out  NUM_CH*DATA_W   per-channel data
//  wb_retire_cnt_o       out  CNT_W           count of beats accepted by WB
// BEHAVIOUR
//  Reset (rst=0, async): main/skid valid=0, mem_ready_o=1, all wb_* outputs 0, counter 0.
//  Storage: main entry (drives wb_* directly from flops) + skid entry.
//  in_xfer  = mem_valid_i & mem_ready_o;  out_xfer = wb_valid_o & wb_ready_i.
//  mem_ready_o = !skid_valid (flop output, no combinational path from wb_ready_i).
//  Next-state per clock (flush_i=0):
//   - main empty or out_xfer: main <= skid if skid_valid, else input if in_xfer, else empty.
//   - skid consumed into main and in_xfer same cycle: input goes to main-after-skid,
//     i.e. skid <= input (skid_valid stays 1); otherwise skid_valid <= 0.
//   - main full, !out_xfer, in_xfer: skid <= input, skid_valid <= 1.
//   - order is strictly preserved: input never overtakes skid, skid never overtakes main.
//  Latency: input beat visible on wb_* one cycle after in_xfer when pipe empty.
//  Throughput: 1 beat/cycle sustained while wb_ready_i=1.
//  Enable masking on capture: en[c] stored as en_i[c] & !(ZERO_SUPP & addr[c]==0).
//  When an entry becomes empty its stored en bits are cleared; addr/data hold last value.
//  Flush (flush_i=1): main_valid, skid_valid, all en bits <= 0 next edge; in_xfer in the
//   flush cycle is discarded; out_xfer in the flush cycle still counts. mem_ready_o=1 after.
//  Retire counter: +1 on every out_xfer, wraps 2^CNT_W-1 -> 0; unaffected by flush.
//  Reset mid-operation: all entries lost immediately, outputs to reset values async.
//  Full condition: main+skid valid -> mem_ready_o=0; a beat offered is not taken.
// TESTING
//  1. Reset then mem_valid_i=1, en=1, addr=5, data=0xDEADBEEF, wb_ready_i=1 ->
//     next cycle wb_valid_o=1, en=1, addr=5, data=0xDEADBEEF; counter=1 after accept.
//  2. wb_ready_i=0, push beats A,B,C back-to-back -> A in main, B in skid, mem_ready_o=0
//     on 3rd cycle, C held upstream; release ready -> A,B,C delivered in order, no loss.
//  3. ZERO_SUPP=1, NUM_CH=2: ch0 addr=0 en=1, ch1 addr=7 en=1 -> wb_write_reg_en_o=2'b10.
//  4. Main+skid full, flush_i=1 with mem_valid_i=1 -> next cycle wb_valid_o=0, en=0,
//     mem_ready_o=1; flushed and same-cycle beats never appear on wb_*.
//  5. CNT_W=4, stream 17 accepted beats -> counter reads 1; flush mid-stream keeps count.
//  6. Assert rst low mid-stream with both entries full -> wb_valid_o=0, en=0,
//     counter=0 immediately (before next clk edge), mem_ready_o=1.

Source files
------------

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer.
// The main entry drives the write-back outputs straight from flops. The skid
// entry absorbs one beat while WB stalls, so the upstream ready is a pure flop
// output with no combinational path from wb_ready_i.
// Beat order is fixed: the skid entry only ever refills main, and a new input
// only lands in skid when main is occupied.
module mem_wb_skid_reg #(
  parameter int NUM_CH    = 1,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int ZERO_SUPP = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [NUM_CH-1:0]        mem_write_reg_en_i,
  input  logic [NUM_CH*ADDR_W-1:0] mem_write_reg_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] mem_write_reg_data_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [NUM_CH-1:0]        wb_write_reg_en_o,
  output logic [NUM_CH*ADDR_W-1:0] wb_write_reg_addr_o,
  output logic [NUM_CH*DATA_W-1:0] wb_write_reg_data_o,
  output logic [CNT_W-1:0]         wb_retire_cnt_o
);

  localparam int AW = NUM_CH * ADDR_W;
  localparam int DW = NUM_CH * DATA_W;

  // Drop the write enable of any channel that targets the hardwired zero register.
  function automatic logic [NUM_CH-1:0] mask_en(input logic [NUM_CH-1:0] en,
                                                input logic [AW-1:0]     addr);
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m[c] = en[c] & !((ZERO_SUPP != 0) && (addr[c*ADDR_W +: ADDR_W] == '0));
    end
    return m;
  endfunction

  // Main entry (visible on wb_*) and skid entry.
  logic              r_main_vld;
  logic [NUM_CH-1:0] r_main_en;
  logic [AW-1:0]     r_main_addr;
  logic [DW-1:0]     r_main_data;
  logic              r_skid_vld;
  logic [NUM_CH-1:0] r_skid_en;
  logic [AW-1:0]     r_skid_addr;
  logic [DW-1:0]     r_skid_data;
  logic [CNT_W-1:0]  r_cnt;

  // Handshake and next-state controls.
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_free;
  logic [NUM_CH-1:0] w_in_en;
  logic              w_main_vld_nx;
  logic [NUM_CH-1:0] w_main_en_nx;
  logic              w_main_ld;
  logic              w_main_from_skid;
  logic              w_skid_vld_nx;
  logic [NUM_CH-1:0] w_skid_en_nx;
  logic              w_skid_ld;

  assign mem_ready_o = !r_skid_vld;
  assign w_in_xfer   = mem_valid_i & mem_ready_o;
  assign w_out_xfer  = r_main_vld & wb_ready_i;
  assign w_main_free = !r_main_vld | w_out_xfer;
  assign w_in_en     = mask_en(mem_write_reg_en_i, mem_write_reg_addr_i);

  // Decide where each entry's next contents come from; flush empties both.
  always_comb begin
    w_main_vld_nx    = r_main_vld;
    w_main_en_nx     = r_main_en;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_vld_nx    = r_skid_vld;
    w_skid_en_nx     = r_skid_en;
    w_skid_ld        = 1'b0;
    if (flush_i) begin
      w_main_vld_nx = 1'b0;
      w_main_en_nx  = '0;
      w_skid_vld_nx = 1'b0;
      w_skid_en_nx  = '0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        w_main_vld_nx    = 1'b1;
        w_main_en_nx     = r_skid_en;
        w_main_ld        = 1'b1;
        w_main_from_skid = 1'b1;
        if (w_in_xfer) begin
          w_skid_vld_nx = 1'b1;
          w_skid_en_nx  = w_in_en;
          w_skid_ld     = 1'b1;
        end else begin
          w_skid_vld_nx = 1'b0;
          w_skid_en_nx  = '0;
        end
      end else if (w_in_xfer) begin
        w_main_vld_nx = 1'b1;
        w_main_en_nx  = w_in_en;
        w_main_ld     = 1'b1;
      end else begin
        w_main_vld_nx = 1'b0;
        w_main_en_nx  = '0;
      end
    end else if (w_in_xfer) begin
      w_skid_vld_nx = 1'b1;
      w_skid_en_nx  = w_in_en;
      w_skid_ld     = 1'b1;
    end
  end

  // Valid and enable state for both entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_vld <= 1'b0;
      r_main_en  <= '0;
      r_skid_vld <= 1'b0;
      r_skid_en  <= '0;
    end else begin
      r_main_vld <= w_main_vld_nx;
      r_main_en  <= w_main_en_nx;
      r_skid_vld <= w_skid_vld_nx;
      r_skid_en  <= w_skid_en_nx;
    end
  end

  // Main payload drives the outputs, so it clears on reset; it holds when emptied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_addr <= '0;
      r_main_data <= '0;
    end else if (w_main_ld) begin
      r_main_addr <= w_main_from_skid ? r_skid_addr : mem_write_reg_addr_i;
      r_main_data <= w_main_from_skid ? r_skid_data : mem_write_reg_data_i;
    end
  end

  // Skid payload is never observed while its valid is low, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_skid_ld) begin
      r_skid_addr <= mem_write_reg_addr_i;
      r_skid_data <= mem_write_reg_data_i;
    end
  end

  // Retire counter: one per beat accepted by WB, wraps naturally, ignores flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_out_xfer) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign wb_valid_o          = r_main_vld;
  assign wb_write_reg_en_o   = r_main_en;
  assign wb_write_reg_addr_o = r_main_addr;
  assign wb_write_reg_data_o = r_main_data;
  assign wb_retire_cnt_o     = r_cnt;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: directed scenarios plus random traffic, checked
// against a queue model of the in-flight beats.
module tb_mem_wb_skid_reg;

  localparam int NUM_CH    = 2;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int ZERO_SUPP = 1;
  localparam int CNT_W     = 4;
  localparam int AW        = NUM_CH * ADDR_W;
  localparam int DW        = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [NUM_CH-1:0] mem_write_reg_en_i;
  logic [AW-1:0]     mem_write_reg_addr_i;
  logic [DW-1:0]     mem_write_reg_data_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [NUM_CH-1:0] wb_write_reg_en_o;
  logic [AW-1:0]     wb_write_reg_addr_o;
  logic [DW-1:0]     wb_write_reg_data_o;
  logic [CNT_W-1:0]  wb_retire_cnt_o;

  mem_wb_skid_reg #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ZERO_SUPP(ZERO_SUPP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_write_reg_en_i(mem_write_reg_en_i),
    .mem_write_reg_addr_i(mem_write_reg_addr_i),
    .mem_write_reg_data_i(mem_write_reg_data_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_write_reg_en_o(wb_write_reg_en_o),
    .wb_write_reg_addr_o(wb_write_reg_addr_o),
    .wb_write_reg_data_o(wb_write_reg_data_o),
    .wb_retire_cnt_o(wb_retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] en;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
  } beat_t;

  // Model: FIFO of beats held by the block (capacity 2), plus the retire count.
  beat_t       m_q[$];
  int unsigned m_cnt;
  int unsigned m_total;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t cur_in();
    beat_t b;
    b.addr = mem_write_reg_addr_i;
    b.data = mem_write_reg_data_i;
    for (int c = 0; c < NUM_CH; c++)
      b.en[c] = mem_write_reg_en_i[c] &&
                !(ZERO_SUPP != 0 && mem_write_reg_addr_i[c*ADDR_W +: ADDR_W] == 0);
    return b;
  endfunction

  task automatic check_outputs();
    bit exp_v;
    exp_v = (m_q.size() > 0);
    chk("wb_valid", 64'(wb_valid_o), 64'(exp_v));
    chk("wb_en", 64'(wb_write_reg_en_o), exp_v ? 64'(m_q[0].en) : 64'd0);
    if (exp_v) begin
      chk("wb_addr", 64'(wb_write_reg_addr_o), 64'(m_q[0].addr));
      chk("wb_data", 64'(wb_write_reg_data_o), 64'(m_q[0].data));
    end
    chk("mem_ready", 64'(mem_ready_o), 64'(m_q.size() < 2));
    chk("retire_cnt", 64'(wb_retire_cnt_o), 64'(m_cnt));
  endtask

  task automatic model_update();
    bit in_x, out_x;
    if (!rst) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      in_x  = mem_valid_i && (m_q.size() < 2);
      out_x = (m_q.size() > 0) && wb_ready_i;
      if (out_x) begin
        void'(m_q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_total++;
      end
      if (flush_i) m_q.delete();
      else if (in_x) m_q.push_back(cur_in());
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model on the edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit v, input logic [NUM_CH-1:0] en,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mem_valid_i          = v;
    mem_write_reg_en_i   = en;
    mem_write_reg_addr_i = addr;
    mem_write_reg_data_i = data;
  endtask

  task automatic drive_rand(input bit v);
    logic [AW-1:0] a;
    a = AW'($urandom);
    if ($urandom_range(0, 3) == 0) a[ADDR_W-1:0] = '0;
    drive(v, NUM_CH'($urandom), a, {$urandom, $urandom});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"}, 64'(wb_valid_o), 64'd0);
    chk({tag, "_en"}, 64'(wb_write_reg_en_o), 64'd0);
    chk({tag, "_addr"}, 64'(wb_write_reg_addr_o), 64'd0);
    chk({tag, "_data"}, 64'(wb_write_reg_data_o), 64'd0);
    chk({tag, "_rdy"}, 64'(mem_ready_o), 64'd1);
    chk({tag, "_cnt"}, 64'(wb_retire_cnt_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    m_cnt = 0;
    m_total = 0;
    rst = 1'b0;
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    drive(1'b0, '0, '0, '0);
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: single beat, one-cycle latency, counter after accept.
    wb_ready_i = 1'b1;
    drive(1'b1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF});
    cycle();
    mem_valid_i = 1'b0;
    chk("t1_vld", 64'(wb_valid_o), 64'd1);
    chk("t1_en", 64'(wb_write_reg_en_o), 64'd1);
    chk("t1_addr", 64'(wb_write_reg_addr_o[ADDR_W-1:0]), 64'd5);
    chk("t1_data", 64'(wb_write_reg_data_o[DATA_W-1:0]), 64'hDEADBEEF);
    cycle();
    chk("t1_cnt", 64'(wb_retire_cnt_o), 64'd1);

    // 2: back-pressure, A and B stored, C held upstream, then in-order drain.
    wb_ready_i = 1'b0;
    drive(1'b1, 2'b11, {5'd1, 5'd2}, {32'hB0B0_0001, 32'hA0A0_000A});
    cycle();
    drive(1'b1, 2'b11, {5'd3, 5'd4}, {32'hB0B0_0002, 32'hA0A0_000B});
    cycle();
    chk("t2_rdy_full", 64'(mem_ready_o), 64'd0);
    drive(1'b1, 2'b11, {5'd5, 5'd6}, {32'hB0B0_0003, 32'hA0A0_000C});
    cycle();
    cycle();
    chk("t2_head_A", 64'(wb_write_reg_data_o[DATA_W-1:0]), 64'hA0A0_000A);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = mem_valid_i && (m_q.size() < 2);
      cycle();
      if (acc) mem_valid_i = 1'b0;
    end
    chk("t2_drained_cnt", 64'(wb_retire_cnt_o), 64'd4);

    // 3: zero-register suppression on channel 0 only.
    wb_ready_i = 1'b0;
    drive(1'b1, 2'b11, {5'd7, 5'd0}, {32'h7777_7777, 32'h0000_0000});
    cycle();
    mem_valid_i = 1'b0;
    chk("t3_en", 64'(wb_write_reg_en_o), 64'b10);
    wb_ready_i = 1'b1;
    cycle();

    // 4: flush with both entries full and a beat offered.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    flush_i = 1'b1;
    drive_rand(1'b1);
    cycle();
    flush_i = 1'b0;
    mem_valid_i = 1'b0;
    chk("t4_vld", 64'(wb_valid_o), 64'd0);
    chk("t4_en", 64'(wb_write_reg_en_o), 64'd0);
    chk("t4_rdy", 64'(mem_ready_o), 64'd1);
    wb_ready_i = 1'b1;
    cycle();
    cycle();

    // 5: counter wrap at CNT_W=4 across a mid-stream flush.
    rst = 1'b0;
    #1;
    m_q.delete();
    m_cnt = 0;
    m_total = 0;
    cycle();
    rst = 1'b1;
    wb_ready_i = 1'b1;
    for (int i = 0; i < 40 && m_total < 17; i++) begin
      drive_rand(1'b1);
      flush_i = (i == 6);
      cycle();
    end
    flush_i = 1'b0;
    mem_valid_i = 1'b0;
    chk("t5_cnt_wrap", 64'(wb_retire_cnt_o), 64'd1);

    // 6: async reset with both entries full.
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4 && m_q.size() < 2; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    mem_valid_i = 1'b0;
    chk("t6_full", 64'(mem_ready_o), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6");
    m_q.delete();
    m_cnt = 0;
    cycle();
    rst = 1'b1;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      wb_ready_i = ($urandom_range(0, 2) != 0);
      flush_i    = ($urandom_range(0, 31) == 0);
      cycle();
    end
    flush_i = 1'b0;
    mem_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
